registro_universal: RTL and testbench
=====================================

# registro_universal

Parametrised universal register, the successor to the single-bit load-enable flip-flop. It holds a WIDTH-bit word that can be held, cleared, parallel-loaded, shifted, rotated or counted. It is the general storage and sequencing element for datapath registers, serial converters and small counters in the course designs. All outputs are registered; the block has no combinational input-to-output paths.

## Interface
- `WIDTH`, 8, word width in bits; valid range ≥ 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `clr`  input  1  synchronous clear.
- `carga`  input  1  operation enable; when 0, the register holds.
- `op`  input  3  operation select; valid only while `carga`=1.
- `d`  input  WIDTH  parallel load data.
- `sl_in`  input  1  serial bit shifted into bit 0 on shift-left.
- `sr_in`  input  1  serial bit shifted into bit WIDTH-1 on shift-right.
- `q`  output  WIDTH  register contents.
- `so`  output  1  last bit shifted or rotated out.
- `tc`  output  1  terminal-count flag; set when the last count wrapped.

## Operation
- Priority:
  - `reset`=0 beats everything else.
  - `clr`=1 is next: on the clock edge, `q`, `so` and `tc` go to 0.
  - `carga`=1 selects `op` next.
  - Otherwise every output holds.
- `op` encoding:
  - 000 hold.
  - 001 load: `q`←`d`.
  - 010 shift left: `q`←{q[W-2:0], sl_in}, `so`←q[W-1].
  - 011 shift right: `q`←{sr_in, q[W-1:1]}, `so`←q[0].
  - 100 rotate left: `q`←{q[W-2:0], q[W-1]}, `so`←q[W-1].
  - 101 rotate right: `q`←{q[0], q[W-1:1]}, `so`←q[0].
  - 110 count up: `q`←q+1 modulo 2^WIDTH.
  - 111 count down: `q`←q−1 modulo 2^WIDTH.
- `so` changes only on ops 010–101; all other ops leave it unchanged.
- `tc`:
  - Updated on every cycle with `carga`=1.
  - Set to 1 on count up from all-ones to 0.
  - Set to 1 on count down from 0 to all-ones.
  - Set to 0 on any other enabled op, including hold (000).
  - When `carga`=0, `tc` holds.
- Arithmetic is unsigned, truncated to WIDTH bits with no saturation. Wrap-around is reported only through `tc`.
- Every sequential assignment is non-blocking. Next-state logic is combinational and uses blocking assignments.

## Timing
- Latency: all effects appear one clock after the rising edge that samples the inputs. There is one operation per cycle.
- Reset:
  - `reset` falling clears `q`, `so` and `tc` to 0 immediately, with no clock needed.
  - While `reset`=0, clock edges have no effect.
  - On the first rising edge after `reset` returns to 1, the normal priority order applies.
- Reset mid-operation: in-progress shifts or counts are lost. There is no resume state.
- `clr` together with `carga`: `clr` wins and `op` is ignored that cycle.
- `op` changing while `carga`=0: no effect.
- Inputs must be stable around the rising edge of `clk`. The block has no internal synchronisers.

## Configuration
- Macro: `REGU_COUNT_EN`.
- Defined:
  - Ops 110 and 111 count as specified.
  - The incrementer/decrementer and the `tc` flop are built.
- Undefined:
  - Ops 110 and 111 behave as hold (000).
  - `tc` is tied to constant 0.
  - No adder logic is synthesised.
  - All other ops are unchanged.

## Structure
- Shared package/header `registro_universal_pkg`:
  - op-code localparams `OP_HOLD`, `OP_LOAD`, `OP_SHL`, `OP_SHR`, `OP_ROL`, `OP_ROR`, `OP_INC`, `OP_DEC`;
  - the op field width (3).
- One sub-module, `celda_universal`:
  - a 1-bit cell with async active-low reset, sync clear and enable;
  - it takes next-value `d` and stores it.
- The top level computes the WIDTH-bit next value, instantiates WIDTH cells in a generate loop, and keeps `so` and `tc` as separate flops with the same reset behaviour.

## Test plan
- Reset: with WIDTH=8, `q`=8'hA5, drive `reset`=0 between clock edges → `q`=0, `so`=0, `tc`=0 immediately; clock edges during reset leave all outputs at 0.
- Load/hold: `carga`=1, op=001, `d`=8'h3C → `q`=8'h3C after one edge; then `carga`=0 with op=010 for 3 cycles → `q` stays 8'h3C.
- Shift:
  - From `q`=8'h81, shift left with `sl_in`=0 → `q`=8'h02, `so`=1.
  - Then shift right with `sr_in`=1 → `q`=8'h81, `so`=0.
- Rotate: from `q`=8'h01, eight rotate-right ops → `q` returns to 8'h01, and `so`=1 after the first op.
- Count (macro defined):
  - From `q`=8'hFE, count up twice → `q`=8'hFF with `tc`=0, then `q`=8'h00 with `tc`=1.
  - Count down from 0 → `q`=8'hFF, `tc`=1.
  - Macro undefined: the same stimulus leaves `q` unchanged and `tc`=0.
- Priority: `clr`=1 with `carga`=1, op=001, `d`=8'hFF → `q`=0, `tc`=0, `so`=0.

Source files
------------

// File: rtl/registro_universal_pkg.sv
// Shared op-code definitions for registro_universal and its cells.
package registro_universal_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b101;
    localparam logic [OP_W-1:0] OP_INC  = 3'b110;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b111;

endpackage

// File: rtl/registro_universal_celda.sv
// celda_universal: one storage bit with async active-low reset, sync clear and enable.
module celda_universal (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    logic bit_q;

    // Reset and clear dominate; otherwise capture d when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_q <= 1'b0;
        end else if (clr) begin
            bit_q <= 1'b0;
        end else if (en) begin
            bit_q <= d;
        end
    end

    assign q = bit_q;

endmodule

// File: rtl/registro_universal.sv
// registro_universal: WIDTH-bit hold/load/shift/rotate/count register.
// Optional feature: define REGU_COUNT_EN to build the up/down counter and tc flag;
// without it ops 110/111 act as hold and tc is constant 0.
module registro_universal
    import registro_universal_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             carga,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] d,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             tc
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic             so_q;
    logic             so_d;

    // Next word and serial-out value for the selected operation.
    always_comb begin
        word_d = word_q;
        so_d   = so_q;
        unique case (op)
            OP_LOAD: word_d = d;
            OP_SHL: begin
                word_d = {word_q[WIDTH-2:0], sl_in};
                so_d   = word_q[WIDTH-1];
            end
            OP_SHR: begin
                word_d = {sr_in, word_q[WIDTH-1:1]};
                so_d   = word_q[0];
            end
            OP_ROL: begin
                word_d = {word_q[WIDTH-2:0], word_q[WIDTH-1]};
                so_d   = word_q[WIDTH-1];
            end
            OP_ROR: begin
                word_d = {word_q[0], word_q[WIDTH-1:1]};
                so_d   = word_q[0];
            end
`ifdef REGU_COUNT_EN
            OP_INC:  word_d = word_q + WIDTH'(1);
            OP_DEC:  word_d = word_q - WIDTH'(1);
`endif
            default: word_d = word_q;
        endcase
    end

    // Storage: one cell per bit, enabled only while carga is high.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        celda_universal u_cell (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .en    (carga),
            .d     (word_d[i]),
            .q     (word_q[i])
        );
    end

    // Serial-out flop, same reset/clear/enable behaviour as the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            so_q <= 1'b0;
        end else if (clr) begin
            so_q <= 1'b0;
        end else if (carga) begin
            so_q <= so_d;
        end
    end

`ifdef REGU_COUNT_EN
    logic tc_q;
    logic tc_d;

    // Terminal count: set only when an enabled count wraps, cleared by any other enabled op.
    always_comb begin
        tc_d = 1'b0;
        if (op == OP_INC) begin
            tc_d = &word_q;
        end else if (op == OP_DEC) begin
            tc_d = ~|word_q;
        end
    end

    // Terminal-count flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tc_q <= 1'b0;
        end else if (clr) begin
            tc_q <= 1'b0;
        end else if (carga) begin
            tc_q <= tc_d;
        end
    end

    assign tc = tc_q;
`else
    assign tc = 1'b0;
`endif

    assign q  = word_q;
    assign so = so_q;

endmodule

// File: tb/tb_registro_universal.sv
// Self-checking bench for registro_universal (WIDTH=8) against an arithmetic reference model.
module tb_registro_universal;

    localparam int unsigned WIDTH = 8;
    localparam int MOD = 256;

    logic             clk = 1'b0;
    logic             reset;
    logic             clr;
    logic             carga;
    logic [2:0]       op;
    logic [WIDTH-1:0] d;
    logic             sl_in;
    logic             sr_in;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             tc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_q  = 0;
    int m_so = 0;
    int m_tc = 0;

`ifdef REGU_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    registro_universal #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .carga (carga),
        .op    (op),
        .d     (d),
        .sl_in (sl_in),
        .sr_in (sr_in),
        .q     (q),
        .so    (so),
        .tc    (tc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".q"},  int'(q),  m_q);
        check_val({tag, ".so"}, int'(so), m_so);
        check_val({tag, ".tc"}, int'(tc), m_tc);
    endtask

    // Model one clock edge from the operation's arithmetic meaning.
    task automatic model_edge(input bit c, input bit ca, input int o, input int dv,
                              input int sl, input int sr);
        int msb;
        int lsb;
        msb = m_q / (MOD / 2);
        lsb = m_q % 2;
        if (c) begin
            m_q = 0; m_so = 0; m_tc = 0;
        end else if (ca) begin
            m_tc = 0;
            case (o)
                1: m_q = dv;
                2: begin m_so = msb; m_q = (m_q * 2) % MOD + sl; end
                3: begin m_so = lsb; m_q = m_q / 2 + sr * (MOD / 2); end
                4: begin m_so = msb; m_q = (m_q * 2) % MOD + msb; end
                5: begin m_so = lsb; m_q = m_q / 2 + lsb * (MOD / 2); end
                6: if (COUNT_EN) begin m_tc = (m_q == MOD - 1) ? 1 : 0; m_q = (m_q + 1) % MOD; end
                7: if (COUNT_EN) begin m_tc = (m_q == 0) ? 1 : 0; m_q = (m_q + MOD - 1) % MOD; end
                default: ;
            endcase
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model and compare.
    task automatic step(input string tag, input bit c, input bit ca, input int o, input int dv,
                        input int sl, input int sr);
        clr   = c;
        carga = ca;
        op    = 3'(o);
        d     = 8'(dv);
        sl_in = 1'(sl);
        sr_in = 1'(sr);
        @(posedge clk);
        #1;
        if (reset) model_edge(c, ca, o, dv, sl, sr);
        check_all(tag);
    endtask

    // Assert reset between edges and verify the immediate clear.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        m_q = 0; m_so = 0; m_tc = 0;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; clr = 1'b0; carga = 1'b0; op = 3'd0; d = 8'h00; sl_in = 1'b0; sr_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("por");
        reset = 1'b1;

        // Async reset from a loaded value, then edges during reset
        step("load_a5", 0, 1, 1, 8'hA5, 0, 0);
        check_val("load_a5.lit", int'(q), 8'hA5);
        async_reset("async_rst");
        step("rst_edge1", 0, 1, 1, 8'hFF, 1, 1);
        step("rst_edge2", 0, 1, 6, 8'hFF, 1, 1);
        check_val("rst_edge.lit", int'(q), 0);
        reset = 1'b1;

        // Load then hold with op changing under carga=0
        step("load_3c", 0, 1, 1, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step("hold", 0, 0, 2, 8'h00, 1, 1);
        check_val("hold.lit", int'(q), 8'h3C);

        // Shift left then right
        step("load_81", 0, 1, 1, 8'h81, 0, 0);
        step("shl", 0, 1, 2, 0, 0, 0);
        check_val("shl.lit_q", int'(q), 8'h02);
        check_val("shl.lit_so", int'(so), 1);
        step("shr", 0, 1, 3, 0, 0, 1);
        check_val("shr.lit_q", int'(q), 8'h81);
        check_val("shr.lit_so", int'(so), 0);

        // Eight rotate-rights return to start
        step("load_01", 0, 1, 1, 8'h01, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step("ror", 0, 1, 5, 0, 0, 0);
            if (i == 0) check_val("ror1.lit_so", int'(so), 1);
        end
        check_val("ror8.lit_q", int'(q), 8'h01);
        step("rol", 0, 1, 4, 0, 0, 0);

        // Count wrap up and down
        step("load_fe", 0, 1, 1, 8'hFE, 0, 0);
        step("inc1", 0, 1, 6, 0, 0, 0);
        step("inc2", 0, 1, 6, 0, 0, 0);
        check_val("inc2.lit_q", int'(q), COUNT_EN ? 8'h00 : 8'hFE);
        check_val("inc2.lit_tc", int'(tc), COUNT_EN ? 1 : 0);
        step("hold_clr_tc", 0, 1, 0, 0, 0, 0);
        step("load_00", 0, 1, 1, 8'h00, 0, 0);
        step("dec", 0, 1, 7, 0, 0, 0);
        check_val("dec.lit_q", int'(q), COUNT_EN ? 8'hFF : 8'h00);
        check_val("dec.lit_tc", int'(tc), COUNT_EN ? 1 : 0);
        step("tc_hold", 0, 0, 1, 8'h55, 0, 0);

        // Clear beats load
        step("shl_so", 0, 1, 4, 0, 0, 0);
        step("clr_prio", 1, 1, 1, 8'hFF, 1, 1);
        check_val("clr_prio.lit", int'(q), 0);

        // Randomised traffic with occasional clear and async reset
        for (int i = 0; i < 600; i++) begin
            step("rand", ($urandom_range(15) == 0), ($urandom_range(3) != 0),
                 int'($urandom_range(7)), int'($urandom_range(255)),
                 int'($urandom_range(1)), int'($urandom_range(1)));
            if ($urandom_range(59) == 0) begin
                async_reset("rand_rst");
                step("rand_in_rst", 0, 1, 1, int'($urandom_range(255)), 0, 0);
                reset = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
